riscv_multicycle_ctrl: RTL and testbench

//  Multi-cycle main-control FSM that sequences the RV64I datapath (PC, regfile, ALU, single shared memory port).

---
 rtl/riscv_multicycle_ctrl_pkg.sv | 49 ++++
 rtl/riscv_multicycle_ctrl_if.sv | 40 ++++
 rtl/riscv_multicycle_ctrl_wait_timer.sv | 29 ++
 rtl/riscv_multicycle_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_riscv_multicycle_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_multicycle_ctrl_pkg.sv
// Shared opcodes, ALUOp codes, state encoding and control-word layout for the multi-cycle controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_multicycle_ctrl_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_WB_ALU   = 4'd7,
        ST_WB_MEM   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_TRAP     = 4'd10
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_addr_sel;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       memto_reg;
        logic       reg_write;
        logic       branch;
        logic [1:0] alu_op;
        logic       pc_write;
        logic       ir_write;
        logic       retire;
    } ctrl_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: decode inputs, memory handshake, control strobes, status.
// Latency: n/a (wires only).
// Backpressure: memory stalls the controller by withholding mem_ready while mem_req is high.
interface riscv_multicycle_ctrl_if #(parameter int CNT_W = 32);

    logic [6:0]       opcode;
    logic             zero;
    logic             mem_ready;

    logic             mem_req;
    logic             mem_addr_sel;
    logic             mem_read;
    logic             mem_write;
    logic             alu_src;
    logic             memto_reg;
    logic             reg_write;
    logic             branch;
    logic [1:0]       alu_op;
    logic             pc_write;
    logic             ir_write;
    logic             retire;
    logic [CNT_W-1:0] retired_cnt;
    logic             illegal;
    logic             timeout_err;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_addr_sel, mem_read, mem_write, alu_src, memto_reg,
               reg_write, branch, alu_op, pc_write, ir_write, retire,
               retired_cnt, illegal, timeout_err
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_addr_sel, mem_read, mem_write, alu_src, memto_reg,
               reg_write, branch, alu_op, pc_write, ir_write, retire,
               retired_cnt, illegal, timeout_err
    );

endinterface

// File: rtl/riscv_multicycle_ctrl_wait_timer.sv
// Counts consecutive non-ready memory cycles and flags the last one allowed before a trap.
// Latency: expired is combinational from the registered count.
// Backpressure: none; clear has priority over inc.
module riscv_multicycle_ctrl_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    logic [7:0] wait_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (inc) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // A ready arriving while expired is high still completes; only a miss traps.
    assign expired = (wait_cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV64I main control FSM: sequences fetch/decode/execute/memory/writeback, counts retires, traps.
// Latency: branch 3, R/I/store 4, load 5 cycles with zero-wait memory; +1 per memory wait cycle.
// Backpressure: holds in memory states until mem_ready; traps after TIMEOUT consecutive misses.
module riscv_multicycle_ctrl
    import riscv_multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    riscv_multicycle_ctrl_if.master bus
);

    state_t           state;
    state_t           state_nxt;
    state_t           done_nxt;
    ctrl_t            ctl;
    ctrl_t            ctl_out;
    logic             wait_clr;
    logic             wait_inc;
    logic             expired;
    logic             set_illegal;
    logic             set_timeout;
    logic [CNT_W-1:0] retired_cnt;
    logic             illegal;
    logic             timeout_err;

    riscv_multicycle_ctrl_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (wait_clr),
        .inc     (wait_inc),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        done_nxt    = ST_FETCH;
        ctl         = '0;
        wait_clr    = 1'b1;
        wait_inc    = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;

        case (state)
            ST_FETCH: begin
                ctl.mem_req  = 1'b1;
                ctl.mem_read = 1'b1;
                ctl.ir_write = bus.mem_ready;
                ctl.pc_write = bus.mem_ready;
                done_nxt     = ST_DECODE;
            end
            ST_DECODE: begin
                case (bus.opcode)
                    OP_R:         state_nxt = ST_EXEC_R;
                    OP_I:         state_nxt = ST_EXEC_I;
                    OP_LD, OP_SD: state_nxt = ST_MEM_ADDR;
                    OP_BEQ:       state_nxt = ST_BRANCH;
                    default: begin
                        state_nxt   = ST_TRAP;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            ST_EXEC_R: begin
                ctl.alu_op = ALUOP_FUNCT;
                state_nxt  = ST_WB_ALU;
            end
            ST_EXEC_I: begin
                ctl.alu_op  = ALUOP_FUNCT;
                ctl.alu_src = 1'b1;
                state_nxt   = ST_WB_ALU;
            end
            ST_MEM_ADDR: begin
                ctl.alu_op  = ALUOP_ADD;
                ctl.alu_src = 1'b1;
                state_nxt   = (bus.opcode == OP_SD) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                ctl.mem_req      = 1'b1;
                ctl.mem_read     = 1'b1;
                ctl.mem_addr_sel = 1'b1;
                ctl.alu_src      = 1'b1;
                done_nxt         = ST_WB_MEM;
            end
            ST_MEM_WR: begin
                ctl.mem_req      = 1'b1;
                ctl.mem_write    = 1'b1;
                ctl.mem_addr_sel = 1'b1;
                ctl.alu_src      = 1'b1;
                ctl.retire       = bus.mem_ready;
                done_nxt         = ST_FETCH;
            end
            ST_WB_ALU: begin
                ctl.reg_write = 1'b1;
                ctl.retire    = 1'b1;
                state_nxt     = ST_FETCH;
            end
            ST_WB_MEM: begin
                ctl.reg_write = 1'b1;
                ctl.memto_reg = 1'b1;
                ctl.retire    = 1'b1;
                state_nxt     = ST_FETCH;
            end
            ST_BRANCH: begin
                ctl.alu_op   = ALUOP_SUB;
                ctl.branch   = 1'b1;
                ctl.pc_write = bus.zero;
                ctl.retire   = 1'b1;
                state_nxt    = ST_FETCH;
            end
            ST_TRAP: begin
                state_nxt = ST_TRAP;
            end
            default: begin
                state_nxt = ST_TRAP;
            end
        endcase

        // Shared handshake for every state that owns the memory port.
        if (is_mem_state(state)) begin
            if (bus.mem_ready) begin
                state_nxt = done_nxt;
            end else if (expired) begin
                state_nxt   = ST_TRAP;
                set_timeout = 1'b1;
            end else begin
                wait_clr = 1'b0;
                wait_inc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_cnt <= '0;
            illegal     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (ctl.retire) begin
                retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (set_timeout) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Reset forces every strobe low at once so an in-flight request is abandoned asynchronously.
    assign ctl_out = reset ? ctl : '0;

    assign bus.mem_req      = ctl_out.mem_req;
    assign bus.mem_addr_sel = ctl_out.mem_addr_sel;
    assign bus.mem_read     = ctl_out.mem_read;
    assign bus.mem_write    = ctl_out.mem_write;
    assign bus.alu_src      = ctl_out.alu_src;
    assign bus.memto_reg    = ctl_out.memto_reg;
    assign bus.reg_write    = ctl_out.reg_write;
    assign bus.branch       = ctl_out.branch;
    assign bus.alu_op       = ctl_out.alu_op;
    assign bus.pc_write     = ctl_out.pc_write;
    assign bus.ir_write     = ctl_out.ir_write;
    assign bus.retire       = ctl_out.retire;
    assign bus.retired_cnt  = retired_cnt;
    assign bus.illegal      = illegal;
    assign bus.timeout_err  = timeout_err;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Bench for riscv_multicycle_ctrl: per-instruction vector table, randomized instruction stream
// against an arithmetic latency model, and hand sequences for trap, timeout and mid-access reset.
module tb_riscv_multicycle_ctrl;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] I   = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] SD  = 7'b0100011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_ret = 0;

    riscv_multicycle_ctrl_if #(.CNT_W(32)) bus ();
    riscv_multicycle_ctrl_if #(.CNT_W(3))  bus3 ();

    assign bus3.opcode    = bus.opcode;
    assign bus3.zero      = bus.zero;
    assign bus3.mem_ready = bus.mem_ready;

    riscv_multicycle_ctrl #(.TIMEOUT(15), .CNT_W(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    riscv_multicycle_ctrl #(.TIMEOUT(15), .CNT_W(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic       z;
        int         fw, dw;
        int         cyc, rw, rw_first, pcw, mw, m2r, dmem, br;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [13:0] outs();
        return {bus.mem_req, bus.mem_addr_sel, bus.mem_read, bus.mem_write, bus.alu_src,
                bus.memto_reg, bus.reg_write, bus.branch, bus.alu_op, bus.pc_write,
                bus.ir_write, bus.retire, 1'b0};
    endfunction

    // Reference: cycles and strobe counts of one instruction from the latency rules.
    task automatic model(input logic [6:0] op, input logic z, input int fw, input int dw,
                         output int cyc, output int rw, output int pcw);
        cyc = 0; rw = 0; pcw = 1;
        if (op == R || op == I) begin
            cyc = 4 + fw; rw = 1;
        end else if (op == LD) begin
            cyc = 5 + fw + dw; rw = 1;
        end else if (op == SD) begin
            cyc = 4 + fw + dw;
        end else if (op == BQ) begin
            cyc = 3 + fw; pcw = 1 + int'(z);
        end
    endtask

    // Drives one instruction with a memory that waits fw cycles on fetch and dw on data.
    task automatic run_instr(input logic [6:0] op, input logic z, input int fw, input int dw,
                             output int cycles, output int rw, output int rw_first, output int pcw,
                             output int mw, output int m2r, output int dmem, output int br);
        bit active = 0;
        int left = 0;
        bit done;
        cycles = 0; rw = 0; rw_first = 0; pcw = 0; mw = 0; m2r = 0; dmem = 0; br = 0;
        bus.opcode = op;
        bus.zero   = z;
        for (int c = 1; c <= 100; c++) begin
            bus.mem_ready = 1'b0;
            if (bus.mem_req) begin
                if (!active) begin
                    active = 1;
                    left   = bus.mem_addr_sel ? dw : fw;
                end
                if (left == 0) begin
                    bus.mem_ready = 1'b1;
                    active        = 0;
                end else begin
                    left--;
                end
            end else begin
                active = 0;
            end
            #1;
            if (bus.reg_write) begin
                rw++;
                if (rw_first == 0) rw_first = c;
            end
            if (bus.pc_write) pcw++;
            if (bus.mem_write) mw++;
            if (bus.memto_reg && bus.reg_write) m2r++;
            if (bus.mem_req && bus.mem_addr_sel) dmem++;
            if (bus.branch && bus.alu_op == 2'b01) br++;
            done = bus.retire;
            @(negedge clk);
            if (done) begin
                cycles = c;
                break;
            end
        end
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        int cyc, rw, rwf, pcw, mw, m2r, dmem, br;
        int ecyc, erw, epcw;
        int cnt;
        bit got;
        logic [6:0] ops[5];
        logic [6:0] op;
        logic z;
        int fw, dw;

        ops = '{R, I, LD, SD, BQ};
        tbl[0] = '{"add",        R,  1'b0, 0, 0, 4, 1, 4, 1, 0, 0, 0, 0};
        tbl[1] = '{"addi_fw2",   I,  1'b0, 2, 0, 6, 1, 6, 1, 0, 0, 0, 0};
        tbl[2] = '{"ld_dw3",     LD, 1'b0, 0, 3, 8, 1, 8, 1, 0, 1, 4, 0};
        tbl[3] = '{"ld_fw1",     LD, 1'b1, 1, 0, 6, 1, 6, 1, 0, 1, 1, 0};
        tbl[4] = '{"sd_fw1_dw1", SD, 1'b0, 1, 1, 6, 0, 0, 1, 2, 0, 2, 0};
        tbl[5] = '{"sd",         SD, 1'b0, 0, 0, 4, 0, 0, 1, 1, 0, 1, 0};
        tbl[6] = '{"beq_taken",  BQ, 1'b1, 0, 0, 3, 0, 0, 2, 0, 0, 0, 1};
        tbl[7] = '{"beq_not",    BQ, 1'b0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 1};
        tbl[8] = '{"beq_fw4",    BQ, 1'b1, 4, 2, 7, 0, 0, 2, 0, 0, 0, 1};

        bus.opcode    = R;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        // Reset state
        #2;
        chk("reset_outputs", outs(), 0);
        chk("reset_retired", bus.retired_cnt, 0);
        chk("reset_flags", {bus.illegal, bus.timeout_err}, 0);
        chk("reset_retired_w3", bus3.retired_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("fetch_after_reset", {bus.mem_req, bus.mem_read, bus.mem_addr_sel}, 3'b110);

        // Vector table
        foreach (tbl[k]) begin
            run_instr(tbl[k].op, tbl[k].z, tbl[k].fw, tbl[k].dw, cyc, rw, rwf, pcw, mw, m2r, dmem, br);
            exp_ret++;
            chk({tbl[k].name, "_cycles"},   cyc,  tbl[k].cyc);
            chk({tbl[k].name, "_regwrite"}, rw,   tbl[k].rw);
            chk({tbl[k].name, "_rw_cycle"}, rwf,  tbl[k].rw_first);
            chk({tbl[k].name, "_pcwrite"},  pcw,  tbl[k].pcw);
            chk({tbl[k].name, "_memwrite"}, mw,   tbl[k].mw);
            chk({tbl[k].name, "_memtoreg"}, m2r,  tbl[k].m2r);
            chk({tbl[k].name, "_datamem"},  dmem, tbl[k].dmem);
            chk({tbl[k].name, "_branch"},   br,   tbl[k].br);
            chk({tbl[k].name, "_retired"},  bus.retired_cnt, exp_ret);
            chk({tbl[k].name, "_ret_wrap"}, bus3.retired_cnt, exp_ret % 8);
        end

        // Randomized stream
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 4)];
            z  = 1'($urandom_range(0, 1));
            fw = $urandom_range(0, 4);
            dw = $urandom_range(0, 4);
            model(op, z, fw, dw, ecyc, erw, epcw);
            run_instr(op, z, fw, dw, cyc, rw, rwf, pcw, mw, m2r, dmem, br);
            exp_ret++;
            chk("rand_cycles",   cyc, ecyc);
            chk("rand_regwrite", rw,  erw);
            chk("rand_pcwrite",  pcw, epcw);
            chk("rand_retired",  bus.retired_cnt, exp_ret);
            chk("rand_ret_wrap", bus3.retired_cnt, exp_ret % 8);
        end

        // Illegal opcode traps after DECODE and stays there
        bus.opcode    = BAD;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 chk("illegal_set", bus.illegal, 1);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            bus.mem_ready = c[0];
            bus.zero      = ~c[0];
            #1 if (outs() != 0) cnt++;
            @(negedge clk);
        end
        chk("trap_outputs_zero", cnt, 0);
        chk("trap_no_retire", bus.retired_cnt, exp_ret);
        chk("illegal_sticky", bus.illegal, 1);
        chk("trap_no_timeout", bus.timeout_err, 0);
        reset = 1'b0;
        #1 chk("illegal_cleared", bus.illegal, 0);
        chk("reset_clears_cnt", bus.retired_cnt, 0);
        exp_ret = 0;
        @(negedge clk);
        reset = 1'b1;

        // Fetch never answered: 15 wait cycles then trap
        bus.opcode    = R;
        bus.mem_ready = 1'b0;
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            #1 if (bus.mem_req) cnt++;
            @(negedge clk);
        end
        chk("timeout_req_cycles", cnt, 15);
        chk("timeout_err_set", bus.timeout_err, 1);
        chk("timeout_req_dropped", bus.mem_req, 0);
        reset = 1'b0;
        #1 chk("timeout_err_cleared", bus.timeout_err, 0);
        @(negedge clk);
        reset = 1'b1;

        // Ready on the 15th cycle still completes
        for (int c = 1; c <= 14; c++) begin
            bus.mem_ready = 1'b0;
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        #1 chk("ready15_ir_write", bus.ir_write, 1);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1 chk("ready15_no_trap", bus.timeout_err, 0);
        chk("ready15_decode_idle", bus.mem_req, 0);
        got = 0;
        for (int c = 0; c < 10; c++) begin
            #1 if (bus.retire) got = 1;
            @(negedge clk);
            if (got) break;
        end
        exp_ret++;
        chk("ready15_retire_seen", got, 1);
        chk("ready15_retired", bus.retired_cnt, exp_ret);

        // Reset asserted while a store waits in MEM_WR
        bus.opcode    = SD;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("memwr_active", {bus.mem_req, bus.mem_write, bus.mem_addr_sel}, 3'b111);
        #2 reset = 1'b0;
        #1 chk("memwr_abort", {bus.mem_req, bus.mem_write}, 2'b00);
        chk("memwr_reset_cnt", bus.retired_cnt, 0);
        exp_ret = 0;
        @(negedge clk);
        reset = 1'b1;
        #1 chk("restart_fetch", {bus.mem_req, bus.mem_read, bus.mem_write, bus.mem_addr_sel}, 4'b1100);
        run_instr(R, 1'b0, 0, 0, cyc, rw, rwf, pcw, mw, m2r, dmem, br);
        exp_ret++;
        chk("restart_add_cycles", cyc, 4);
        chk("restart_retired", bus.retired_cnt, exp_ret);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
